// File: rtl/stepper_router_pkg.sv
`timescale 1ns/1ps
// Shared channel state type and width helpers for the stepper router.
package stepper_router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } chan_state_e;

    function automatic int unsigned sel_width(input int unsigned n_axes);
        return $clog2(n_axes + 1);
    endfunction

    function automatic int unsigned mot_width(input int unsigned n_motors);
        return (n_motors > 1) ? $clog2(n_motors) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/stepper_channel.sv
`timescale 1ns/1ps
// One driver channel: dir setup, step width timing, one-deep pending step,
// sticky overrun and deferred (shadow -> active) selection config.
module stepper_channel
    import stepper_router_pkg::*;
#(
    parameter int unsigned DIR_SETUP = 20,
    parameter int unsigned PULSE_W   = 10,
    parameter int unsigned SEL_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             edge_i,
    input  logic             dir_i,
    input  logic             cfg_wr_i,
    input  logic [SEL_W-1:0] cfg_sel_i,
    input  logic             cfg_inv_i,
    output logic [SEL_W-1:0] act_sel_o,
    output logic             act_inv_o,
    output logic             step_o,
    output logic             dir_o,
    output logic             busy_o,
    output logic             overrun_o
);

    localparam int unsigned CNT_W = cnt_width(DIR_SETUP, PULSE_W);

    chan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d, ovr_q, ovr_d;
    logic             step_q, step_d, dir_q, dir_d, busy_q, busy_d;
    logic [SEL_W-1:0] act_sel_q, act_sel_d, sh_sel_q, sh_sel_d;
    logic             act_inv_q, act_inv_d, sh_inv_q, sh_inv_d, sh_vld_q, sh_vld_d;
    logic             cnt_zero, want_step, dir_chg, fire, xfer;

    assign cnt_zero  = (cnt_q == '0);
    assign want_step = edge_i | pend_q;
    assign dir_chg   = (dir_i != dir_q);
    assign fire      = ((state_q == IDLE) && !dir_chg && want_step) ||
                       ((state_q == SETUP) && cnt_zero && want_step);
    assign xfer      = (state_q == IDLE) && !pend_q && sh_vld_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            ovr_q     <= 1'b0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            busy_q    <= 1'b0;
            act_sel_q <= '0;
            act_inv_q <= 1'b0;
            sh_sel_q  <= '0;
            sh_inv_q  <= 1'b0;
            sh_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            ovr_q     <= ovr_d;
            step_q    <= step_d;
            dir_q     <= dir_d;
            busy_q    <= busy_d;
            act_sel_q <= act_sel_d;
            act_inv_q <= act_inv_d;
            sh_sel_q  <= sh_sel_d;
            sh_inv_q  <= sh_inv_d;
            sh_vld_q  <= sh_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (dir_chg) state_d = SETUP;
                     else if (want_step) state_d = HIGH;
            SETUP:   if (cnt_zero) state_d = want_step ? HIGH : IDLE;
            HIGH:    if (cnt_zero) state_d = LOW;
            LOW:     if (cnt_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        step_d    = step_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        ovr_d     = ovr_q;
        act_sel_d = act_sel_q;
        act_inv_d = act_inv_q;
        sh_sel_d  = sh_sel_q;
        sh_inv_d  = sh_inv_q;
        sh_vld_d  = sh_vld_q;

        unique case (state_q)
            IDLE: begin
                if (dir_chg) begin
                    dir_d = dir_i;
                    cnt_d = CNT_W'(DIR_SETUP);
                end else if (want_step) begin
                    step_d = 1'b1;
                    cnt_d  = CNT_W'(PULSE_W);
                end
            end
            SETUP: if (cnt_zero && want_step) begin
                step_d = 1'b1;
                cnt_d  = CNT_W'(PULSE_W);
            end
            HIGH: if (cnt_zero) begin
                step_d = 1'b0;
                cnt_d  = CNT_W'(PULSE_W);
            end
            default: ;
        endcase

        // A fresh edge arriving alongside a consumed pending step takes its slot.
        if (fire) begin
            pend_d = edge_i & pend_q;
        end else if (edge_i) begin
            if (pend_q) ovr_d = 1'b1;
            else        pend_d = 1'b1;
        end

        if (xfer) begin
            act_sel_d = sh_sel_q;
            act_inv_d = sh_inv_q;
            sh_vld_d  = 1'b0;
        end
        if (cfg_wr_i) begin
            sh_sel_d = cfg_sel_i;
            sh_inv_d = cfg_inv_i;
            sh_vld_d = 1'b1;
            ovr_d    = 1'b0;
        end

        busy_d = (state_d != IDLE) || sh_vld_d;
    end

    assign act_sel_o = act_sel_q;
    assign act_inv_o = act_inv_q;
    assign step_o    = step_q;
    assign dir_o     = dir_q;
    assign busy_o    = busy_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/stepper_router.sv
`timescale 1ns/1ps
// Routes N_AXES step/dir generators onto N_MOTORS timed driver channels
// with per-channel direction inversion and deferred selection changes.
module stepper_router
    import stepper_router_pkg::*;
#(
    parameter int unsigned N_AXES    = 3,
    parameter int unsigned N_MOTORS  = 4,
    parameter int unsigned DIR_SETUP = 20,
    parameter int unsigned PULSE_W   = 10,
    parameter int unsigned SEL_W     = sel_width(N_AXES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_AXES-1:0]                axis_step,
    input  logic [N_AXES-1:0]                axis_dir,
    input  logic                             cfg_wr,
    input  logic [mot_width(N_MOTORS)-1:0]   cfg_motor,
    input  logic [SEL_W-1:0]                 cfg_sel,
    input  logic                             cfg_invert,
    output logic [N_MOTORS-1:0]              step,
    output logic [N_MOTORS-1:0]              dir,
    output logic [N_MOTORS-1:0]              busy,
    output logic [N_MOTORS-1:0]              overrun
);

    localparam int unsigned MOT_W = mot_width(N_MOTORS);

    logic [N_AXES-1:0] s1_step_q, s1_step_d, s2_step_q, s2_step_d, s1_dir_q, s1_dir_d;
    logic [N_AXES-1:0] edge_c;
    logic [SEL_W-1:0]  cfg_sel_c;

    always_comb begin
        s1_step_d = axis_step;
        s2_step_d = s1_step_q;
        s1_dir_d  = axis_dir;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_step_q <= '0;
            s2_step_q <= '0;
            s1_dir_q  <= '0;
        end else begin
            s1_step_q <= s1_step_d;
            s2_step_q <= s2_step_d;
            s1_dir_q  <= s1_dir_d;
        end
    end

    assign edge_c    = s1_step_q & ~s2_step_q;
    // Out-of-range select codes park the channel.
    assign cfg_sel_c = (cfg_sel > SEL_W'(N_AXES)) ? '0 : cfg_sel;

    for (genvar m = 0; m < N_MOTORS; m++) begin : g_ch
        logic [SEL_W-1:0] act_sel;
        logic             act_inv, wr_c;
        logic             eff_edge_d, eff_dir_d, eff_edge_q, eff_dir_q;

        assign wr_c = cfg_wr && (cfg_motor == MOT_W'(m));

        always_comb begin
            eff_edge_d = 1'b0;
            eff_dir_d  = act_inv;
            for (int a = 0; a < int'(N_AXES); a++) begin
                if (act_sel == SEL_W'(a + 1)) begin
                    eff_edge_d = edge_c[a];
                    eff_dir_d  = s1_dir_q[a] ^ act_inv;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                eff_edge_q <= 1'b0;
                eff_dir_q  <= 1'b0;
            end else begin
                eff_edge_q <= eff_edge_d;
                eff_dir_q  <= eff_dir_d;
            end
        end

        stepper_channel #(
            .DIR_SETUP (DIR_SETUP),
            .PULSE_W   (PULSE_W),
            .SEL_W     (SEL_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .edge_i    (eff_edge_q),
            .dir_i     (eff_dir_q),
            .cfg_wr_i  (wr_c),
            .cfg_sel_i (cfg_sel_c),
            .cfg_inv_i (cfg_invert),
            .act_sel_o (act_sel),
            .act_inv_o (act_inv),
            .step_o    (step[m]),
            .dir_o     (dir[m]),
            .busy_o    (busy[m]),
            .overrun_o (overrun[m])
        );
    end

endmodule

// File: tb/tb_stepper_router.sv
`timescale 1ns/1ps
// Self-checking bench for stepper_router: directed scenarios plus random
// traffic, compared every cycle against a time-stamp based channel model.
module tb_stepper_router;

    localparam int NA = 3;
    localparam int NM = 4;
    localparam int D  = 20;
    localparam int P  = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] axis_step, axis_dir;
    logic       cfg_wr;
    logic [1:0] cfg_motor;
    logic [2:0] cfg_sel;
    logic       cfg_invert;
    logic [3:0] step, dir, busy, overrun;

    stepper_router #(
        .N_AXES(NA), .N_MOTORS(NM), .DIR_SETUP(D), .PULSE_W(P), .SEL_W(3)
    ) dut (
        .clk(clk), .rst(rst), .axis_step(axis_step), .axis_dir(axis_dir),
        .cfg_wr(cfg_wr), .cfg_motor(cfg_motor), .cfg_sel(cfg_sel), .cfg_invert(cfg_invert),
        .step(step), .dir(dir), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: each channel is idle, in a dir-setup window, or in a pulse
    // window, each described by its start edge index.
    int   n;
    bit   ms1[NA], ms2[NA], ms1d[NA];
    bit   meedge[NM], medir[NM];
    int   kind[NM], t0[NM];
    bit   pend[NM], ovr[NM], mdir[NM];
    int   act_sel[NM], sh_sel[NM];
    bit   act_inv[NM], sh_inv[NM], sh_vld[NM];
    logic [3:0] x_step, x_dir, x_busy, x_ovr;

    logic [3:0] prev_step;
    int         rises[NM];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0;
        for (int a = 0; a < NA; a++) begin ms1[a] = 0; ms2[a] = 0; ms1d[a] = 0; end
        for (int m = 0; m < NM; m++) begin
            meedge[m] = 0; medir[m] = 0; kind[m] = 0; t0[m] = 0;
            pend[m] = 0; ovr[m] = 0; mdir[m] = 0;
            act_sel[m] = 0; sh_sel[m] = 0; act_inv[m] = 0; sh_inv[m] = 0; sh_vld[m] = 0;
        end
        x_step = '0; x_dir = '0; x_busy = '0; x_ovr = '0;
    endtask

    task automatic model_edge();
        bit ne[NM], nd[NM];
        bit e, d, fire, xfer;
        for (int m = 0; m < NM; m++) begin
            ne[m] = 0;
            nd[m] = act_inv[m];
            if (act_sel[m] >= 1) begin
                ne[m] = ms1[act_sel[m]-1] && !ms2[act_sel[m]-1];
                nd[m] = ms1d[act_sel[m]-1] ^ act_inv[m];
            end
        end
        for (int m = 0; m < NM; m++) begin
            e = meedge[m];
            d = medir[m];
            if (kind[m] == 2 && n >= t0[m] + 2*P + 3) kind[m] = 0;
            fire = 0;
            xfer = (kind[m] == 0) && !pend[m] && sh_vld[m];
            if (kind[m] == 0) begin
                if (d != mdir[m]) begin
                    mdir[m] = d; kind[m] = 1; t0[m] = n;
                end else if (e || pend[m]) fire = 1;
            end else if (kind[m] == 1 && n == t0[m] + D + 1) begin
                if (e || pend[m]) fire = 1;
                else kind[m] = 0;
            end
            if (fire) begin
                kind[m] = 2; t0[m] = n;
                pend[m] = e && pend[m];
            end else if (e) begin
                if (pend[m]) ovr[m] = 1;
                else pend[m] = 1;
            end
            if (xfer) begin
                act_sel[m] = sh_sel[m]; act_inv[m] = sh_inv[m]; sh_vld[m] = 0;
            end
            if (cfg_wr && int'(cfg_motor) == m) begin
                sh_sel[m] = (int'(cfg_sel) > NA) ? 0 : int'(cfg_sel);
                sh_inv[m] = cfg_invert;
                sh_vld[m] = 1;
                ovr[m]    = 0;
            end
            x_step[m] = (kind[m] == 2) && (n - t0[m] <= P);
            x_busy[m] = (kind[m] == 1) || (kind[m] == 2 && n < t0[m] + 2*P + 2) || sh_vld[m];
            x_dir[m]  = mdir[m];
            x_ovr[m]  = ovr[m];
        end
        for (int m = 0; m < NM; m++) begin meedge[m] = ne[m]; medir[m] = nd[m]; end
        for (int a = 0; a < NA; a++) begin
            ms2[a] = ms1[a]; ms1[a] = axis_step[a]; ms1d[a] = axis_dir[a];
        end
        n++;
    endtask

    // One clock: model the edge, compare just after it, return at the next negedge.
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        chk("step", 32'(step), 32'(x_step));
        chk("dir", 32'(dir), 32'(x_dir));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("overrun", 32'(overrun), 32'(x_ovr));
        for (int m = 0; m < NM; m++) if (step[m] && !prev_step[m]) rises[m]++;
        prev_step = step;
        @(negedge clk);
    endtask

    task automatic cfg(input int mot, input int sel, input bit inv);
        cfg_wr = 1; cfg_motor = 2'(mot); cfg_sel = 3'(sel); cfg_invert = inv;
        cyc();
        cfg_wr = 0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int quiet = 0;
        for (int i = 0; i < max_cyc && quiet < 4; i++) begin
            cyc();
            if (busy == 4'b0 && step == 4'b0) quiet++;
            else quiet = 0;
        end
        chk("settle", 32'(quiet), 32'd4);
    endtask

    task automatic clr_rises();
        for (int m = 0; m < NM; m++) rises[m] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int hi, rise;
        rst = 1; axis_step = '0; axis_dir = '0;
        cfg_wr = 0; cfg_motor = '0; cfg_sel = '0; cfg_invert = 0;
        prev_step = '0;
        clr_rises();
        model_reset();
        @(negedge clk);
        repeat (3) cyc();
        chk("rst_step", 32'(step), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst = 0;

        // Basic routed pulse: latency and width.
        cfg(1, 2, 0);
        wait_idle(60);
        axis_step[1] = 1; cyc(); chk("t1_k", 32'(step), 0);
        axis_step[1] = 0; cyc(); chk("t1_k1", 32'(step), 0);
        cyc(); chk("t1_rise", 32'(step), 32'h2);
        hi = 1;
        for (int i = 0; i < 20; i++) begin cyc(); if (step[1]) hi++; end
        chk("t1_width", 32'(hi), 32'd11);

        // Inverted dir change with simultaneous step.
        cfg(0, 1, 1);
        wait_idle(80);
        chk("t2_dir_pre", 32'(dir[0]), 1);
        axis_dir[0] = 1; axis_step[0] = 1; cyc();
        axis_step[0] = 0; cyc(); chk("t2_dir_hold", 32'(dir[0]), 1);
        cyc(); chk("t2_dir_chg", 32'(dir[0]), 0);
        rise = -1;
        for (int c = 1; c <= 30; c++) begin cyc(); if (step[0] && rise < 0) rise = c; end
        chk("t2_setup", 32'(rise), 32'd21);
        wait_idle(60);

        // Pending step and overrun.
        clr_rises();
        for (int j = 0; j < 3; j++) begin
            axis_step[0] = 1; cyc(); axis_step[0] = 0; cyc(); cyc();
        end
        repeat (45) cyc();
        chk("t3_pulses", 32'(rises[0]), 32'd2);
        chk("t3_ovr", 32'(overrun[0]), 1);
        cfg(0, 1, 1);
        chk("t3_ovr_clr", 32'(overrun[0]), 0);
        wait_idle(60);

        // Reselect mid-pulse.
        axis_step[0] = 1; cyc(); axis_step[0] = 0; cyc(); cyc();
        chk("t4_rise", 32'(step[0]), 1);
        hi = 1;
        for (int i = 0; i < 30; i++) begin
            if (i == 4) begin cfg_wr = 1; cfg_motor = 2'd0; cfg_sel = 3'd3; cfg_invert = 0; end
            else cfg_wr = 0;
            cyc();
            if (step[0]) hi++;
            if (i == 21) chk("t4_busy", 32'(busy[0]), 1);
        end
        chk("t4_width", 32'(hi), 32'd11);
        wait_idle(60);
        clr_rises();
        axis_step[2] = 1; cyc(); axis_step[2] = 0;
        repeat (30) cyc();
        chk("t4_new_axis", 32'(rises[0]), 1);
        clr_rises();
        axis_step[0] = 1; cyc(); axis_step[0] = 0;
        repeat (30) cyc();
        chk("t4_old_axis", 32'(rises[0]), 0);

        // Parked channels, including an out-of-range select code.
        cfg(2, 0, 1);
        cfg(3, 7, 1);
        wait_idle(80);
        chk("t5_dir", 32'(dir[3:2]), 32'h3);
        clr_rises();
        for (int i = 0; i < 40; i++) begin
            axis_step = (i % 3 == 0) ? 3'b111 : 3'b000;
            if (i % 10 == 0) axis_dir = ~axis_dir;
            cyc();
        end
        axis_step = '0;
        chk("t5_park_step", 32'(rises[2] + rises[3]), 0);
        chk("t5_dir_hold", 32'(dir[3:2]), 32'h3);
        axis_dir = '0;
        wait_idle(200);

        // Reset while a pulse is high.
        axis_step[1] = 1; cyc(); axis_step[1] = 0; cyc(); cyc();
        chk("t6_rise", 32'(step[1]), 1);
        cyc(); cyc();
        rst = 1;
        #1;
        chk("t6_rst_step", 32'(step), 0);
        chk("t6_rst_dir", 32'(dir), 0);
        cyc(); cyc();
        rst = 0;
        clr_rises();
        repeat (30) cyc();
        chk("t6_no_resume", 32'(rises[1]), 0);

        // Random traffic with occasional reconfiguration and one reset.
        for (int i = 0; i < 4000; i++) begin
            for (int a = 0; a < NA; a++) begin
                axis_step[a] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 60) == 0) axis_dir[a] = ~axis_dir[a];
            end
            cfg_wr     = ($urandom_range(0, 49) == 0);
            cfg_motor  = 2'($urandom_range(0, 3));
            cfg_sel    = 3'($urandom_range(0, 7));
            cfg_invert = 1'($urandom_range(0, 1));
            rst        = (i == 2000);
            cyc();
        end
        rst = 0; cfg_wr = 0; axis_step = '0;
        repeat (5) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
